// File: rtl/plab5_mcore_mem_req_cmsg_queue.sv
// Two-entry FIFO for packed memory-request control messages (no data field).
// Sits between the request-message splitter and the memory/cache request port,
// registering the val/rdy handshake and unpacking the head entry into fields.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   enq_val/enq_rdy/enq_msg
//                         upstream handshake; enq_msg = {type, opaque, addr, len}
//   deq_val/deq_rdy       downstream handshake
//   deq_type/deq_opaque/deq_addr/deq_len
//                         fields of the head entry (stale when deq_val=0)
//   num_free              free entries, 0..2
module plab5_mcore_mem_req_cmsg_queue #(
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_addr_nbits   = 32,
  parameter int unsigned p_data_nbits   = 32,
  localparam int unsigned o = p_opaque_nbits,
  localparam int unsigned a = p_addr_nbits,
  localparam int unsigned d = p_data_nbits,
  localparam int unsigned t = 3,             // VC mem-request type width
  localparam int unsigned l = $clog2(d / 8), // len width, 0 encodes full word
  localparam int unsigned c = t + o + a + l  // control-message width
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq_val,
  output logic         enq_rdy,
  input  logic [c-1:0] enq_msg,
  output logic         deq_val,
  input  logic         deq_rdy,
  output logic [t-1:0] deq_type,
  output logic [o-1:0] deq_opaque,
  output logic [a-1:0] deq_addr,
  output logic [l-1:0] deq_len,
  output logic [1:0]   num_free
);

  logic [c-1:0] entry_q [2];
  logic         enq_ptr_q;
  logic         deq_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         enq_fire;
  logic         deq_fire;
  logic [c-1:0] head;

  // No bypass in either direction: enq_rdy depends only on state, never on
  // deq_rdy, and an empty queue never forwards enq_msg to the deq side.
  assign enq_rdy  = (count_q != 2'd2);
  assign deq_val  = (count_q != 2'd0);
  assign num_free = 2'd2 - count_q;

  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  always_comb begin
    count_d = count_q;
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= 2'd0;
      enq_ptr_q <= 1'b0;
      deq_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (enq_fire) enq_ptr_q <= ~enq_ptr_q;
      if (deq_fire) deq_ptr_q <= ~deq_ptr_q;
    end
  end

  // enq_ptr only equals deq_ptr with a valid head when the queue is full, and
  // enq_fire is blocked then, so the head is never overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else if (enq_fire) begin
      entry_q[enq_ptr_q] <= enq_msg;
    end
  end

  assign head       = entry_q[deq_ptr_q];
  assign deq_len    = head[l-1:0];
  assign deq_addr   = head[l+a-1:l];
  assign deq_opaque = head[l+a+o-1:l+a];
  assign deq_type   = head[c-1:l+a+o];

endmodule

// File: doc/plab5_mcore_mem_req_cmsg_queue.md
Name: plab5_mcore_mem_req_cmsg_queue

Overview:
- Two-entry FIFO for packed memory-request control messages (type, opaque, addr, len; no data field).
- Sits directly downstream of the request-message splitter and upstream of the memory/cache request port.
- Decouples the core-side val/rdy handshake from the memory side by one registered stage.
- Unpacks the head entry into separate fields using the standard VC mem-request layout.

Parameters:
- p_opaque_nbits, 8, opaque field width (o)
- p_addr_nbits, 32, address field width (a)
- p_data_nbits, 32, data width of the paired request (d); used only to derive len width
- o, p_opaque_nbits, alias
- a, p_addr_nbits, alias
- d, p_data_nbits, alias
- l, `VC_MEM_REQ_MSG_LEN_NBITS(o,a,d), len field width (2 for d=32)
- c, `VC_MEM_REQ_MSG_NBITS(o,a,d) - d, control-message width (45 for defaults)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- enq_val  in  1  upstream message valid
- enq_rdy  out  1  queue can accept a message
- enq_msg  in  c  packed message: type[c-1:l+a+o], opaque[l+a+o-1:l+a], addr[l+a-1:l], len[l-1:0]
- deq_val  out  1  head entry valid
- deq_rdy  in  1  downstream accepts head
- deq_type  out  `VC_MEM_REQ_MSG_TYPE_NBITS(o,a,d)  head type
- deq_opaque  out  o  head opaque
- deq_addr  out  a  head address
- deq_len  out  l  head length (0 = full word, passed through unchanged)
- num_free  out  2  free entries (0..2)
- All ports carry security label {L}.

Behaviour:
- State: two storage entries of c bits, enq_ptr (1 bit), deq_ptr (1 bit), count (2 bits, 0..2).
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - count=0, both pointers=0, both entries=0.
  - Outputs: enq_rdy=1, deq_val=0, num_free=2, all deq_* fields=0.
- Combinational outputs:
  - enq_rdy = (count != 2).
  - deq_val = (count != 0).
  - num_free = 2 - count.
- Enqueue fires when enq_val && enq_rdy: the entry at enq_ptr is written with enq_msg and enq_ptr toggles.
- Dequeue fires when deq_val && deq_rdy: deq_ptr toggles.
- Count update:
  - enqueue only: count+1.
  - dequeue only: count-1.
  - both: count unchanged.
- Simultaneous enq/deq at count=1: legal; the head is dequeued and the new message is written to the other entry.
- Full (count=2): enq_rdy=0 even if deq_rdy=1 in the same cycle. There is no full-bypass, so the enq_rdy path has no combinational dependence on deq_rdy.
- Empty (count=0): no bypass; a message enqueued in cycle N is first visible on deq_* with deq_val=1 in cycle N+1. Minimum latency is 1 cycle.
- deq_* fields:
  - Combinational slices of the entry at deq_ptr, using the bit ranges given for enq_msg.
  - When empty they show that entry's stale content; consumers qualify with deq_val.
  - Immediately after reset they are 0.
- Head stability: the entry at deq_ptr is not overwritten while deq_val=1, so the head is stable until dequeued.
- Pointers wrap 1->0 naturally (1-bit).
- enq_msg is ignored when enq_val=0 or enq_rdy=0.
- deq_rdy is ignored when deq_val=0; count never underflows.
- Throughput: one message per cycle sustained when deq_rdy is held high.

Test Plan:
- Reset, then idle -> enq_rdy=1, deq_val=0, num_free=2, deq_addr=0x00000000.
- Single message: enq msg {type=1, opaque=0x5A, addr=0x00001000, len=0} with deq_rdy=0 -> next cycle deq_val=1, deq_type=1, deq_opaque=0x5A, deq_addr=0x00001000, deq_len=0, num_free=1.
- Fill: enqueue A (addr 0x10) then B (addr 0x20) with deq_rdy=0 -> enq_rdy=0, num_free=0, head=0x10. Then deq_rdy=1 for two cycles -> addr 0x10 then 0x20 in order, deq_val drops, num_free=2.
- Full plus simultaneous deq_rdy=1 and enq_val=1 carrying C -> C not accepted that cycle; A dequeued; C accepted next cycle; order A, B, C.
- Streaming: 8 back-to-back messages (opaque 0..7, len=3) with deq_rdy=1 throughout -> one dequeue per cycle after 1-cycle latency, count stays 1, pointers wrap correctly, all opaques in order.
- Asynchronous reset asserted mid-cycle with count=2 -> deq_val falls before the next clock edge, num_free=2. After release, an enqueue of addr 0xFFFFFFFC appears as the sole head.
